register_result_status: RTL and testbench

REGISTER_RESULT_STATUS -- requirements
Module: register_result_status

---
 rtl/register_result_status.sv | 76 +++++++
 tb/tb_register_result_status.sv | 123 ++++++++++++
 2 files changed

// File: rtl/register_result_status.sv
// Register result status file: per-register producer tag plus value, with CDB broadcast update.
// Optional feature macro: RRS_CDB_BYPASS_EN (same-cycle CDB forwarding onto the read port).
module register_result_status #(
    parameter int ADDR_W    = 6,
    parameter int UNIT_SIZE = 8,
    parameter int WORD_SIZE = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           rrsr,
    input  logic                        rrswritable,
    input  logic [UNIT_SIZE-1:0]        rrswrite,
    input  logic signed [WORD_SIZE-1:0] rrsinrf,
    input  logic                        check,
    output logic [UNIT_SIZE-1:0]        rrsout,
    output logic signed [WORD_SIZE-1:0] rrsoutrf
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [UNIT_SIZE-1:0] READY = UNIT_SIZE'(8'h7F);

    logic [UNIT_SIZE-1:0]        tag_q [DEPTH];
    logic [UNIT_SIZE-1:0]        tag_d [DEPTH];
    logic signed [WORD_SIZE-1:0] val_q [DEPTH];
    logic signed [WORD_SIZE-1:0] val_d [DEPTH];

    logic bcast_active;
    assign bcast_active = check && (rrswrite != READY);

    // Broadcast is applied to every entry first, then the rename write overrides entry rrsr.
    always_comb begin
        tag_d = tag_q;
        val_d = val_q;
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_d[i] = READY;
                val_d[i] = '0;
            end
        end else begin
            if (bcast_active) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (tag_q[i] == rrswrite) begin
                        tag_d[i] = READY;
                        val_d[i] = rrsinrf;
                    end
                end
            end
            if (rrswritable) begin
                tag_d[rrsr] = rrswrite;
                if (rrswrite == READY) begin
                    val_d[rrsr] = rrsinrf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        val_q <= val_d;
    end

`ifdef RRS_CDB_BYPASS_EN
    always_comb begin
        rrsout   = tag_q[rrsr];
        rrsoutrf = val_q[rrsr];
        if (bcast_active && (tag_q[rrsr] == rrswrite)) begin
            rrsout   = READY;
            rrsoutrf = rrsinrf;
        end
    end
`else
    assign rrsout   = tag_q[rrsr];
    assign rrsoutrf = val_q[rrsr];
`endif

endmodule

// File: tb/tb_register_result_status.sv
// Directed self-checking bench for register_result_status; expectations are hand-computed.
module tb_register_result_status;

    logic               clk = 1'b0;
    logic               rst;
    logic [5:0]         rrsr;
    logic               rrswritable;
    logic [7:0]         rrswrite;
    logic signed [31:0] rrsinrf;
    logic               check;
    logic [7:0]         rrsout;
    logic signed [31:0] rrsoutrf;

    int total = 0;
    int bad   = 0;

    register_result_status #(.ADDR_W(6), .UNIT_SIZE(8), .WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .rrsr(rrsr), .rrswritable(rrswritable),
        .rrswrite(rrswrite), .rrsinrf(rrsinrf), .check(check),
        .rrsout(rrsout), .rrsoutrf(rrsoutrf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Read entry idx combinationally with strobes idle, then compare tag and value.
    task automatic rd(input string name, input logic [5:0] idx, input logic [7:0] etag,
                      input logic [31:0] eval);
        rrswritable = 1'b0;
        check       = 1'b0;
        rrsr        = idx;
        #1;
        chk({name, "_tag"}, {24'h0, rrsout}, {24'h0, etag});
        chk({name, "_val"}, rrsoutrf, eval);
    endtask

    // Drive one clocked operation, then return strobes to idle shortly after the edge.
    task automatic op(input logic r, input logic wr, input logic ck, input logic [5:0] idx,
                      input logic [7:0] tg, input logic [31:0] v);
        rst = r; rrswritable = wr; check = ck; rrsr = idx; rrswrite = tg; rrsinrf = v;
        @(posedge clk);
        #1;
        rst = 1'b0; rrswritable = 1'b0; check = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rrsr = '0; rrswritable = 1'b0; rrswrite = 8'h7F; rrsinrf = '0; check = 1'b0;
        @(negedge clk);

        // Reset, with a conflicting write and check that must be overridden.
        op(1'b1, 1'b1, 1'b1, 6'd0, 8'hA0, 32'd5);
        rd("rst_r0", 6'd0, 8'h7F, 32'd0);
        rd("rst_r31", 6'd31, 8'h7F, 32'd0);
        rd("rst_r63", 6'd63, 8'h7F, 32'd0);

        // Ready write stores the value; a pending rename keeps it.
        op(1'b0, 1'b1, 1'b0, 6'd5, 8'h7F, 32'hFFFF_FFF9);
        rd("wr_ready_r5", 6'd5, 8'h7F, 32'hFFFF_FFF9);
        op(1'b0, 1'b1, 1'b0, 6'd5, 8'hA3, 32'd1000);
        rd("rename_r5", 6'd5, 8'hA3, 32'hFFFF_FFF9);

        // Two entries waiting on the same producer receive one broadcast.
        op(1'b0, 1'b1, 1'b0, 6'd3, 8'hA0, 32'd0);
        op(1'b0, 1'b1, 1'b0, 6'd2, 8'hC1, 32'd0);
        op(1'b0, 1'b1, 1'b0, 6'd9, 8'hC1, 32'd0);
        rd("pend_r2", 6'd2, 8'hC1, 32'd0);
        op(1'b0, 1'b0, 1'b1, 6'd0, 8'hC1, 32'd1234);
        rd("bc_r2", 6'd2, 8'h7F, 32'd1234);
        rd("bc_r9", 6'd9, 8'h7F, 32'd1234);
        rd("bc_r3", 6'd3, 8'hA0, 32'd0);
        rd("bc_r5", 6'd5, 8'hA3, 32'hFFFF_FFF9);

        // Broadcast and rename in the same cycle: rename wins on r2.
        op(1'b0, 1'b1, 1'b0, 6'd2, 8'hC1, 32'd0);
        op(1'b0, 1'b1, 1'b0, 6'd9, 8'hC1, 32'd0);
        op(1'b0, 1'b1, 1'b1, 6'd2, 8'hC1, 32'd555);
        rrsr = 6'd2; #1;
        chk("both_r2_tag", {24'h0, rrsout}, 32'h0000_00C1);
        rd("both_r9", 6'd9, 8'h7F, 32'd555);

        // Broadcast of an unused tag, and of the READY tag, changes nothing.
        op(1'b0, 1'b0, 1'b1, 6'd0, 8'hD5, 32'd77);
        rd("nomatch_r3", 6'd3, 8'hA0, 32'd0);
        rd("nomatch_r2", 6'd2, 8'hC1, 32'd555);
        op(1'b0, 1'b0, 1'b1, 6'd0, 8'h7F, 32'd99);
        rd("readybc_r5", 6'd5, 8'hA3, 32'hFFFF_FFF9);
        rd("readybc_r0", 6'd0, 8'h7F, 32'd0);
        rd("readybc_r3", 6'd3, 8'hA0, 32'd0);

        // Same-cycle read while the CDB carries r4's producer.
        op(1'b0, 1'b1, 1'b0, 6'd4, 8'h85, 32'd0);
        rrsr = 6'd4; rrswrite = 8'h85; rrsinrf = 32'd42; check = 1'b1;
        #1;
`ifdef RRS_CDB_BYPASS_EN
        chk("bypass_tag", {24'h0, rrsout}, 32'h0000_007F);
        chk("bypass_val", rrsoutrf, 32'd42);
`else
        chk("nobypass_tag", {24'h0, rrsout}, 32'h0000_0085);
        chk("nobypass_val", rrsoutrf, 32'd0);
`endif
        @(posedge clk);
        #1;
        check = 1'b0;
        rd("bc_r4", 6'd4, 8'h7F, 32'd42);

        // Reset overrides a simultaneous write.
        op(1'b1, 1'b1, 1'b0, 6'd7, 8'h7F, 32'd11);
        rd("rstwr_r7", 6'd7, 8'h7F, 32'd0);
        rd("rstwr_r5", 6'd5, 8'h7F, 32'd0);
        rd("rstwr_r2", 6'd2, 8'h7F, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
